// File: rtl/ddr_req_arb_pkg.sv
// Shared types and sizing for the two-requester DDR request arbiter.
package ddr_req_arb_pkg;
  localparam int DDR_ARB_NREQ      = 2;
  localparam int DDR_ARB_MAX_OUTST = 64;
  localparam int DDR_ADDR_W        = 32;
  localparam int DDR_DATA_W        = 512;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic [DDR_DATA_W-1:0] data;
  } ddr_wr_t;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
  } ddr_rd_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/ddr_req_arb_rr_arb2.sv
// Two-way round-robin grant; the last accepted requester drops to lowest priority.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);
  logic last;  // reset to 1 so requester 0 is favoured first

  always_comb begin
    gnt = '0;
    if (req[~last])     gnt[~last] = 1'b1;
    else if (req[last]) gnt[last]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)       last <= 1'b1;
    else if (take) last <= gnt[1];
endmodule

// File: rtl/unified_fifo.sv
// Show-ahead FIFO; push while full is accepted only alongside a pop.
module unified_fifo #(
  parameter int    BITS_PER_SYMBOL  = 8,
  parameter int    SYMBOLS_PER_BEAT = 1,
  parameter int    DEPTH            = 64,
  parameter string MEM_TYPE         = "MLAB"
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      wr_en,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] wr_data,
  input  logic                                      rd_en,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] rd_data,
  output logic                                      full,
  output logic                                      empty
);
  localparam int W  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

  // LUT RAM cannot be reset; other styles clear their storage.
  if (MEM_TYPE == "MLAB") begin : g_mlab
    always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wr_data;
  end else begin : g_reg
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/ddr_req_arb.sv
// Two-requester DDR read/write arbiter with in-order response routing.
// Optional statistics counters under DDR_ARB_STATS_EN.
module ddr_req_arb
  import ddr_req_arb_pkg::*;
#(
  parameter int NREQ      = DDR_ARB_NREQ,
  parameter int MAX_OUTST = DDR_ARB_MAX_OUTST
) (
  input  logic                            clk,
  input  logic                            rst,
  input  ddr_wr_t [NREQ-1:0]              req_wr_data,
  input  logic    [NREQ-1:0]              req_wr_valid,
  output logic    [NREQ-1:0]              req_wr_ready,
  input  ddr_rd_t [NREQ-1:0]              req_rd_data,
  input  logic    [NREQ-1:0]              req_rd_valid,
  output logic    [NREQ-1:0]              req_rd_ready,
  output logic    [NREQ-1:0][DDR_DATA_W-1:0] resp_data,
  output logic    [NREQ-1:0]              resp_valid,
  input  logic    [NREQ-1:0]              resp_almost_full,
  output ddr_wr_t                         ddr_wr_req_data,
  output logic                            ddr_wr_req_valid,
  input  logic                            ddr_wr_req_almost_full,
  output ddr_rd_t                         ddr_rd_req_data,
  output logic                            ddr_rd_req_valid,
  input  logic                            ddr_rd_req_almost_full,
  input  logic    [DDR_DATA_W-1:0]        ddr_rd_resp_data,
  input  logic                            ddr_rd_resp_valid,
  output logic                            ddr_rd_resp_almost_full,
  output logic                            err_orphan,
  input  logic    [1:0]                   stat_sel,
  output logic    [31:0]                  stat_csr_readdata
);
  logic [NREQ-1:0] wr_gnt, rd_gnt;
  logic            wr_take, rd_take, resp_pop, rd_room;
  logic            fifo_full, fifo_empty, owner;

  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(req_wr_valid), .take(wr_take), .gnt(wr_gnt));
  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(req_rd_valid), .take(rd_take), .gnt(rd_gnt));

  // A full owner FIFO still takes a read when a response pops it the same cycle.
  assign resp_pop     = ddr_rd_resp_valid & ~fifo_empty;
  assign rd_room      = ~fifo_full | resp_pop;
  assign req_wr_ready = wr_gnt & {NREQ{~ddr_wr_req_almost_full & ~rst}};
  assign req_rd_ready = rd_gnt & {NREQ{~ddr_rd_req_almost_full & rd_room & ~rst}};
  assign wr_take      = |req_wr_ready;
  assign rd_take      = |req_rd_ready;

  unified_fifo #(
    .BITS_PER_SYMBOL(1), .SYMBOLS_PER_BEAT(1), .DEPTH(MAX_OUTST), .MEM_TYPE("MLAB")
  ) u_owner_fifo (
    .clk(clk), .rst(rst), .wr_en(rd_take), .wr_data(rd_gnt[1]),
    .rd_en(ddr_rd_resp_valid), .rd_data(owner), .full(fifo_full), .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ddr_wr_req_valid <= 1'b0;
      ddr_wr_req_data  <= '0;
      ddr_rd_req_valid <= 1'b0;
      ddr_rd_req_data  <= '0;
    end else begin
      ddr_wr_req_valid <= wr_take;
      ddr_rd_req_valid <= rd_take;
      if (wr_take) ddr_wr_req_data <= req_wr_data[wr_gnt[1]];
      if (rd_take) ddr_rd_req_data <= req_rd_data[rd_gnt[1]];
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      resp_valid              <= '0;
      resp_data               <= '0;
      err_orphan              <= 1'b0;
      ddr_rd_resp_almost_full <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (resp_pop) begin
        resp_valid[owner] <= 1'b1;
        resp_data[owner]  <= ddr_rd_resp_data;
      end
      if (ddr_rd_resp_valid & fifo_empty) err_orphan <= 1'b1;
      ddr_rd_resp_almost_full <= |resp_almost_full;
    end

`ifdef DDR_ARB_STATS_EN
  logic [31:0] wr_cnt, rd_cnt, stall_cnt, orphan_cnt;
  logic        stall;

  assign stall = (|req_wr_valid & ddr_wr_req_almost_full) |
                 (|req_rd_valid & ddr_rd_req_almost_full);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_cnt            <= '0;
      rd_cnt            <= '0;
      stall_cnt         <= '0;
      orphan_cnt        <= '0;
      stat_csr_readdata <= '0;
    end else begin
      if (wr_take) wr_cnt    <= sat_inc(wr_cnt);
      if (rd_take) rd_cnt    <= sat_inc(rd_cnt);
      if (stall)   stall_cnt <= sat_inc(stall_cnt);
      if (ddr_rd_resp_valid & fifo_empty) orphan_cnt <= sat_inc(orphan_cnt);
      case (stat_sel)
        2'd0:    stat_csr_readdata <= wr_cnt;
        2'd1:    stat_csr_readdata <= rd_cnt;
        2'd2:    stat_csr_readdata <= stall_cnt;
        default: stat_csr_readdata <= orphan_cnt;
      endcase
    end
`else
  logic unused_stat_sel;
  assign unused_stat_sel   = ^stat_sel;
  assign stat_csr_readdata = '0;
`endif
endmodule

// File: tb/tb_ddr_req_arb.sv
// Directed bench for ddr_req_arb: arbitration, backpressure, routing, orphans, reset.
module tb_ddr_req_arb;
  import ddr_req_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  ddr_wr_t [1:0]        req_wr_data;
  logic    [1:0]        req_wr_valid, req_wr_ready;
  ddr_rd_t [1:0]        req_rd_data;
  logic    [1:0]        req_rd_valid, req_rd_ready;
  logic    [1:0][511:0] resp_data;
  logic    [1:0]        resp_valid, resp_almost_full;
  ddr_wr_t              ddr_wr_req_data;
  logic                 ddr_wr_req_valid, ddr_wr_req_almost_full;
  ddr_rd_t              ddr_rd_req_data;
  logic                 ddr_rd_req_valid, ddr_rd_req_almost_full;
  logic    [511:0]      ddr_rd_resp_data;
  logic                 ddr_rd_resp_valid, ddr_rd_resp_almost_full;
  logic                 err_orphan;
  logic    [1:0]        stat_sel;
  logic    [31:0]       stat_csr_readdata;

  int errs = 0, checks = 0;

  ddr_req_arb dut (
    .clk(clk), .rst(rst),
    .req_wr_data(req_wr_data), .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
    .req_rd_data(req_rd_data), .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_almost_full(resp_almost_full),
    .ddr_wr_req_data(ddr_wr_req_data), .ddr_wr_req_valid(ddr_wr_req_valid),
    .ddr_wr_req_almost_full(ddr_wr_req_almost_full),
    .ddr_rd_req_data(ddr_rd_req_data), .ddr_rd_req_valid(ddr_rd_req_valid),
    .ddr_rd_req_almost_full(ddr_rd_req_almost_full),
    .ddr_rd_resp_data(ddr_rd_resp_data), .ddr_rd_resp_valid(ddr_rd_resp_valid),
    .ddr_rd_resp_almost_full(ddr_rd_resp_almost_full),
    .err_orphan(err_orphan), .stat_sel(stat_sel), .stat_csr_readdata(stat_csr_readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  int n0, n1, acc;

  initial begin
    rst = 1'b1;
    req_wr_valid = '0; req_rd_valid = '0; resp_almost_full = '0;
    ddr_wr_req_almost_full = 1'b0; ddr_rd_req_almost_full = 1'b0;
    ddr_rd_resp_valid = 1'b0; ddr_rd_resp_data = '0; stat_sel = 2'd0;
    req_wr_data[0] = '{addr: 32'hA0, data: 512'h1111};
    req_wr_data[1] = '{addr: 32'hB0, data: 512'h2222};
    req_rd_data[0] = '{addr: 32'hC0};
    req_rd_data[1] = '{addr: 32'hD0};

    // reset state, with requests present while reset is held
    tick();
    req_wr_valid = 2'b11; req_rd_valid = 2'b11;
    #1;
    chk("rst_wr_rdy", 64'(req_wr_ready), 0);
    chk("rst_rd_rdy", 64'(req_rd_ready), 0);
    chk("rst_wr_v", 64'(ddr_wr_req_valid), 0);
    chk("rst_rd_v", 64'(ddr_rd_req_valid), 0);
    chk("rst_resp_v", 64'(resp_valid), 0);
    chk("rst_resp_d", resp_data[0][63:0], 0);
    chk("rst_orphan", 64'(err_orphan), 0);
    chk("rst_stat", 64'(stat_csr_readdata), 0);
    req_wr_valid = '0; req_rd_valid = '0;
    rst = 1'b0;
    tick();

    // continuous writes from both: strict alternation starting at 0
    n0 = 0; n1 = 0;
    req_wr_valid = 2'b11;
    for (int k = 0; k < 100; k++) begin
      #1 chk("wr_rdy_alt", 64'(req_wr_ready), (k % 2) ? 64'd2 : 64'd1);
      tick();
      chk("wr_ddr_v", 64'(ddr_wr_req_valid), 1);
      if (ddr_wr_req_data.addr == 32'hA0 && ddr_wr_req_data.data == 512'h1111) n0++;
      else if (ddr_wr_req_data.addr == 32'hB0 && ddr_wr_req_data.data == 512'h2222) n1++;
    end
    req_wr_valid = '0;
    tick();
    chk("wr_idle_v", 64'(ddr_wr_req_valid), 0);
    chk("wr_cnt0", 64'(n0), 50);
    chk("wr_cnt1", 64'(n1), 50);

    // pointer holds across idle cycles
    req_wr_valid = 2'b11;
    #1 chk("wr_rdy_g0", 64'(req_wr_ready), 1);
    tick();
    req_wr_valid = '0;
    tick(); tick(); tick();
    req_wr_valid = 2'b11;
    #1 chk("wr_rdy_hold", 64'(req_wr_ready), 2);
    ddr_wr_req_almost_full = 1'b1;
    #1 chk("wr_af_rdy", 64'(req_wr_ready), 0);
    tick();
    chk("wr_af_v", 64'(ddr_wr_req_valid), 0);
    req_wr_valid = '0; ddr_wr_req_almost_full = 1'b0;
    do_reset();

    // read almost_full stall for 10 cycles, then resume
    ddr_rd_req_almost_full = 1'b1;
    req_rd_valid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      #1 chk("rd_af_rdy", 64'(req_rd_ready), 0);
      tick();
      chk("rd_af_v", 64'(ddr_rd_req_valid), 0);
    end
    ddr_rd_req_almost_full = 1'b0;
    #1 chk("rd_resume_rdy", 64'(req_rd_ready), 1);
    tick();
    req_rd_valid = '0;
    chk("rd_resume_v", 64'(ddr_rd_req_valid), 1);
    chk("rd_resume_a", 64'(ddr_rd_req_data.addr), 64'hC0);
    tick();
    chk("rd_single_v", 64'(ddr_rd_req_valid), 0);
    do_reset();

    // reads 0,1,1,0 then responses A..D routed in order
    for (int k = 0; k < 4; k++) begin
      req_rd_valid = (k == 1 || k == 2) ? 2'b10 : 2'b01;
      #1 chk("ord_rdy", 64'(req_rd_ready), 64'(req_rd_valid));
      tick();
      chk("ord_addr", 64'(ddr_rd_req_data.addr), (k == 1 || k == 2) ? 64'hD0 : 64'hC0);
    end
    req_rd_valid = '0;
    for (int k = 0; k < 4; k++) begin
      ddr_rd_resp_valid = 1'b1;
      ddr_rd_resp_data = 512'(10 + k);
      tick();
      chk("ord_resp_v", 64'(resp_valid), (k == 1 || k == 2) ? 64'd2 : 64'd1);
      chk("ord_resp_d", resp_data[(k == 1 || k == 2) ? 1 : 0][63:0], 64'(10 + k));
    end
    ddr_rd_resp_valid = 1'b0;
    tick();
    chk("ord_idle", 64'(resp_valid), 0);
    chk("ord_orphan", 64'(err_orphan), 0);
    resp_almost_full = 2'b10;
    tick();
    chk("resp_af_or", 64'(ddr_rd_resp_almost_full), 1);
    resp_almost_full = 2'b00;
    tick();
    chk("resp_af_clr", 64'(ddr_rd_resp_almost_full), 0);
    do_reset();

    // fill owner FIFO with 64 reads, then simultaneous push/pop while full
    acc = 0;
    req_rd_valid = 2'b01;
    for (int k = 0; k < 64; k++) begin
      #1 if (req_rd_ready == 2'b01) acc++;
      tick();
    end
    chk("fill_acc", 64'(acc), 64);
    #1 chk("full_rdy", 64'(req_rd_ready), 0);
    ddr_rd_resp_valid = 1'b1;
    ddr_rd_resp_data = 512'h55;
    #1 chk("full_pp_rdy", 64'(req_rd_ready), 1);
    tick();
    chk("full_pp_resp", 64'(resp_valid), 1);
    chk("full_pp_d", resp_data[0][63:0], 64'h55);
    chk("full_pp_rdv", 64'(ddr_rd_req_valid), 1);
    ddr_rd_resp_valid = 1'b0;
    #1 chk("still_full", 64'(req_rd_ready), 0);
    req_rd_valid = '0;
    acc = 0;
    for (int k = 0; k < 64; k++) begin
      ddr_rd_resp_valid = 1'b1;
      ddr_rd_resp_data = 512'(k);
      tick();
      if (resp_valid == 2'b01) acc++;
    end
    chk("drain_cnt", 64'(acc), 64);
    chk("drain_orphan", 64'(err_orphan), 0);

    // orphan response on empty FIFO
    ddr_rd_resp_data = 512'h77;
    tick();
    ddr_rd_resp_valid = 1'b0;
    chk("orph_resp_v", 64'(resp_valid), 0);
    chk("orph_err", 64'(err_orphan), 1);
    stat_sel = 2'd3;
    tick();
    chk("orph_sticky", 64'(err_orphan), 1);
`ifdef DDR_ARB_STATS_EN
    chk("orph_stat", 64'(stat_csr_readdata), 1);
`else
    chk("orph_stat", 64'(stat_csr_readdata), 0);
`endif
    do_reset();

    // reset discards 5 outstanding reads
    req_rd_valid = 2'b01;
    for (int k = 0; k < 5; k++) tick();
    req_rd_valid = '0;
    chk("pre_rst_v", 64'(ddr_rd_req_valid), 1);
    rst = 1'b1;
    #1 chk("mid_rst_orphan", 64'(err_orphan), 0);
    tick();
    rst = 1'b0;
    tick();
    ddr_rd_resp_valid = 1'b1;
    ddr_rd_resp_data = 512'h99;
    tick();
    ddr_rd_resp_valid = 1'b0;
    chk("post_rst_resp", 64'(resp_valid), 0);
    chk("post_rst_orph", 64'(err_orphan), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule

// File: doc/ddr_req_arb.md
DDR_REQ_ARB -- requirements
Module: ddr_req_arb

Interface
REQ-001 Parameter NREQ, default 2, number of DDR requesters (fixed at 2 in this revision).
REQ-002 Parameter MAX_OUTST, default 64, maximum read requests awaiting response (power of 2).
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_wr_data[i]  in  ddr_wr_t  write request from requester i.
REQ-006 req_wr_valid[i] / req_wr_ready[i]  in / out  1  write handshake; transfer when both are high.
REQ-007 req_rd_data[i]  in  ddr_rd_t  read request from requester i.
REQ-008 req_rd_valid[i] / req_rd_ready[i]  in / out  1  read handshake.
REQ-009 resp_data[i]  out  512  read response to requester i.
REQ-010 resp_valid[i]  out  1  response beat to requester i.
REQ-011 resp_almost_full[i]  in  1  requester i response backpressure.
REQ-012 ddr_wr_req_data / ddr_wr_req_valid / ddr_wr_req_almost_full  out / out / in  ddr_wr_t / 1 / 1  DDR write port.
REQ-013 ddr_rd_req_data / ddr_rd_req_valid / ddr_rd_req_almost_full  out / out / in  ddr_rd_t / 1 / 1  DDR read port.
REQ-014 ddr_rd_resp_data / ddr_rd_resp_valid / ddr_rd_resp_almost_full  in / in / out  512 / 1 / 1  DDR in-order read responses.
REQ-015 stat_csr_readdata  out  32  statistics readout; stat_sel  in  2  selects the counter.

Function
REQ-016 Write and read channels SHALL be arbitrated independently, each using single-beat requests.
REQ-017 Each channel SHALL use round-robin arbitration; the requester granted last has the lowest priority on the next cycle.
REQ-018 req_wr_ready[i] SHALL be combinational: high only when requester i wins the write grant and ddr_wr_req_almost_full=0.
REQ-019 req_rd_ready[i] SHALL be high only when requester i wins the read grant, ddr_rd_req_almost_full=0, and the owner FIFO is not full.
REQ-020 An accepted request SHALL appear on the DDR port through a register, 1 cycle later, with valid asserted for exactly 1 cycle and data unchanged.
REQ-021 Each accepted read SHALL push its requester index into an owner FIFO of depth MAX_OUTST.
REQ-022 Each ddr_rd_resp_valid beat SHALL pop the owner FIFO and be routed, registered with 1-cycle latency, to resp_data/resp_valid of the popped index only.
REQ-023 A push and a pop in the same cycle SHALL leave the occupancy unchanged, including when the FIFO is full.
REQ-024 A response arriving while the owner FIFO is empty is a protocol error: the beat SHALL be dropped and a sticky err_orphan output (1 bit) SHALL be set until reset.
REQ-025 ddr_rd_resp_almost_full SHALL be the registered OR of all resp_almost_full[i].
REQ-026 With no valid requests, the round-robin pointers SHALL hold their state.

Reset
REQ-027 While rst is asserted: all *_valid and *_ready outputs are 0, resp_data is 0, the owner FIFO is empty, round-robin pointers select requester 0 first, err_orphan is 0, and the counters are 0.
REQ-028 rst asserted mid-operation SHALL discard all outstanding ownership; responses arriving after reset SHALL be handled per REQ-024.

Configuration
REQ-029 Macro DDR_ARB_STATS_EN.
- Defined: 32-bit saturating counters are implemented for wr grants, rd grants, almost_full stall cycles, and orphan responses; stat_sel 0..3 selects the counter, and the readout is registered.
- Undefined: the counters are absent and stat_csr_readdata is tied to 0.
- The arbitration behaviour SHALL be identical with and without the macro.

Structure
REQ-030 ddr_wr_t, ddr_rd_t, DDR_ARB_NREQ and DDR_ARB_MAX_OUTST SHALL reside in the shared struct package.
REQ-031 The round-robin grant logic SHALL be a sub-module rr_arb2, instantiated once per channel.
REQ-032 The owner FIFO SHALL be a unified_fifo instance with MEM_TYPE "MLAB" and BITS_PER_SYMBOL 1.

Verification
REQ-033 Both requesters issue continuous writes -> grants alternate 0,1,0,1; 100 writes yield exactly 50 per requester on the DDR port.
REQ-034 ddr_rd_req_almost_full=1 for 10 cycles with both requesters valid -> no ready and no DDR valid during those cycles; resumes the cycle after deassertion.
REQ-035 Reads issued in the order 0,1,1,0, then 4 responses with data 0xA..0xD -> requester 0 gets 0xA,0xD and requester 1 gets 0xB,0xC, each 1 cycle after its response.
REQ-036 Requester 0 issues 64 reads with no responses -> req_rd_ready stays 0 afterwards; one response arriving with a read pending -> simultaneous push/pop, occupancy stays 64.
REQ-037 A response arrives with the owner FIFO empty -> no resp_valid, err_orphan=1; with DDR_ARB_STATS_EN defined, stat_sel=3 reads 1.
REQ-038 rst pulsed with 5 reads outstanding -> the FIFO is empty after reset, and the next response is treated as an orphan.
